// File: rtl/serial_parity_rx.sv
// Bit-serial even-parity frame receiver: LSB-first data bits, then one parity bit, into a one-entry output register.
// Optional feature macro: PERR_CNT_EN adds the saturating perr_count port.
module serial_parity_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              busy
`ifdef PERR_CNT_EN
  ,
  output logic [7:0]        perr_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  function automatic logic parity_step(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   shift_r;
  logic                acc_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                out_perr_r;
  logic                in_ready_s;
  logic                accept_s;
  logic                complete_s;
  logic                perr_new_s;
  logic                busy_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort wins over any accept.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (accept_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (accept_s && (cnt_r == CNT_W'(DATA_W - 1))) begin
          state_nxt_s = ST_PARITY;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (abort || accept_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake and completion decode; only the parity bit can stall.
  always_comb begin
    in_ready_s = 1'b1;
    if ((state_r == ST_PARITY) && out_valid_r && !out_ready) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = 1'b1;
    end
    accept_s   = in_valid && in_ready_s;
    complete_s = accept_s && !abort && (state_r == ST_PARITY);
    perr_new_s = parity_step(acc_r, in_bit);
    busy_s     = (state_r != ST_IDLE);
  end

  // Bit counter, shift register and running parity accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      shift_r <= {DATA_W{1'b0}};
      acc_r   <= 1'b0;
    end else if (abort) begin
      cnt_r <= {CNT_W{1'b0}};
      acc_r <= 1'b0;
    end else if (accept_s) begin
      if (state_r == ST_PARITY) begin
        cnt_r <= {CNT_W{1'b0}};
        acc_r <= 1'b0;
      end else begin
        cnt_r   <= cnt_r + CNT_W'(1);
        acc_r   <= parity_step(acc_r, in_bit);
        shift_r <= {in_bit, shift_r[DATA_W-1:1]};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // One-entry output register; a completing frame overrides the drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_perr_r  <= 1'b0;
    end else if (complete_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= shift_r;
      out_perr_r  <= perr_new_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef PERR_CNT_EN
  logic [7:0] perr_count_r;

  // Saturating count of frames completed with a parity error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_count_r <= 8'd0;
    end else if (complete_s && perr_new_s && (perr_count_r != 8'd255)) begin
      perr_count_r <= perr_count_r + 8'd1;
    end else begin
      perr_count_r <= perr_count_r;
    end
  end

  assign perr_count = perr_count_r;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_perr  = out_perr_r;
  assign busy      = busy_s;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed table-driven bench for serial_parity_rx (DATA_W=8), with hand sequences for stall, abort and reset.
module tb_serial_parity_rx;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_perr;
  logic       busy;
`ifdef PERR_CNT_EN
  logic [7:0] perr_count;
`endif

  int tests;
  int fails;
  int exp_cnt;

  serial_parity_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_perr   (out_perr),
    .busy       (busy)
`ifdef PERR_CNT_EN
    ,
    .perr_count (perr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"},  {24'd0, out_data},  32'd0);
    check({tag, "_out_perr"},  {31'd0, out_perr},  32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
`ifdef PERR_CNT_EN
    check({tag, "_perr_count"}, {24'd0, perr_count}, 32'd0);
`endif
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    exp_cnt   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 8'h01, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b0};
    vecs[5] = '{8'h7E, 1'b1, 8'h7E, 1'b1};

    tick();
    tick();
    check_reset_vals("rst");
    #2 rst_n = 1'b1;
    tick();

    // Table-driven frames with the consumer always ready.
    for (int v = 0; v < 6; v++) begin
      send_bit(vecs[v].data[0]);
      check($sformatf("v%0d_busy_first", v), {31'd0, busy}, 32'd1);
      check($sformatf("v%0d_valid_drained", v), {31'd0, out_valid}, 32'd0);
      for (int i = 1; i < 8; i++) send_bit(vecs[v].data[i]);
      check($sformatf("v%0d_no_valid_before_par", v), {31'd0, out_valid}, 32'd0);
      send_bit(vecs[v].par);
      if (vecs[v].exp_perr) exp_cnt++;
      check($sformatf("v%0d_valid", v), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d_data", v), {24'd0, out_data}, {24'd0, vecs[v].exp_data});
      check($sformatf("v%0d_perr", v), {31'd0, out_perr}, {31'd0, vecs[v].exp_perr});
      check($sformatf("v%0d_busy_done", v), {31'd0, busy}, 32'd0);
`ifdef PERR_CNT_EN
      check($sformatf("v%0d_perr_count", v), {24'd0, perr_count}, exp_cnt);
`endif
    end
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: second frame stalls only at its parity bit.
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    check("bp_valid1", {31'd0, out_valid}, 32'd1);
    check("bp_data1", {24'd0, out_data}, 32'h3C);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_ready_data%0d", i), {31'd0, in_ready}, 32'd1);
      send_bit(1'b1);
    end
    check("bp_ready_par", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    tick();
    tick();
    check("bp_hold_data", {24'd0, out_data}, 32'h3C);
    check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_valid2", {31'd0, out_valid}, 32'd1);
    check("bp_data2", {24'd0, out_data}, 32'hFF);
    check("bp_perr2", {31'd0, out_perr}, 32'd0);
    tick();
    check("bp_drain", {31'd0, out_valid}, 32'd0);

    // Abort mid-frame; the bit presented with abort must be dropped.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("ab_busy_pre", {31'd0, busy}, 32'd1);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("ab_busy_post", {31'd0, busy}, 32'd0);
    check("ab_valid_post", {31'd0, out_valid}, 32'd0);
    send_frame(8'h81, 1'b0);
    check("ab_data", {24'd0, out_data}, 32'h81);
    check("ab_perr", {31'd0, out_perr}, 32'd0);
    check("ab_valid", {31'd0, out_valid}, 32'd1);

    // Abort leaves a pending output untouched.
    out_ready = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab2_valid", {31'd0, out_valid}, 32'd1);
    check("ab2_data", {24'd0, out_data}, 32'h81);
    check("ab2_busy", {31'd0, busy}, 32'd0);

    // Reset mid-frame with a pending output, checked before any clock edge.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("mr_busy_pre", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    #1 rst_n = 1'b1;
    exp_cnt   = 0;
    out_ready = 1'b1;
    tick();
    send_frame(8'h55, 1'b0);
    check("mr_valid", {31'd0, out_valid}, 32'd1);
    check("mr_data", {24'd0, out_data}, 32'h55);
    check("mr_perr", {31'd0, out_perr}, 32'd0);

`ifdef PERR_CNT_EN
    // Counter saturation over 300 back-to-back bad frames.
    for (int f = 0; f < 300; f++) send_frame(8'h01, 1'b0);
    check("sat_count", {24'd0, perr_count}, 32'd255);
    check("sat_perr", {31'd0, out_perr}, 32'd1);
    send_frame(8'h03, 1'b1);
    check("sat_hold", {24'd0, perr_count}, 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
